// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks one UART transmitter to a single message source per message.
// Define UART_TX_ARB_TIMEOUT_EN to add the GO/WAIT watchdog and the sticky timeout_err_o flag.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GAP_CYCLES     = 50,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                       enable_i,      // clock, rising edge
    input  logic                       reset_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [8*NUM_REQ-1:0]       req_data_i,
    input  logic [NUM_REQ-1:0]         req_last_i,
    output logic [NUM_REQ-1:0]         ack_o,
    input  logic                       tx_empty_i,
    output logic                       xmit_go_o,
    output logic [7:0]                 tx_data_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       busy_o,
    output logic                       timeout_err_o
);

    localparam int unsigned OW = $clog2(NUM_REQ);
    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

    typedef enum logic [2:0] {StIdle, StLoad, StGo, StWait, StGap} state_e;

    state_e              state_q;
    logic [OW-1:0]       ptr_q;
    logic [OW-1:0]       owner_q;
    logic                xmit_q;
    logic [7:0]          data_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic                busy_q;
    logic                last_q;
    logic [GW-1:0]       gap_q;
    logic [OW-1:0]       ptr_d;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_q;
    logic          tmo_q;
`endif

    // First requester at or above the priority pointer, wrapping around.
    logic [OW-1:0] pick_idx;
    logic          pick_vld;
    logic [OW:0]   cand;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (OW+1)'(i);
            if (cand >= (OW+1)'(NUM_REQ)) begin
                cand = cand - (OW+1)'(NUM_REQ);
            end
            if (!pick_vld && req_i[cand[OW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[OW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);
    end

    always_ff @(posedge enable_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            xmit_q  <= 1'b0;
            data_q  <= 8'h00;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            gap_q   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            wd_q    <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            wd_q  <= '0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (pick_vld) begin
                        owner_q <= pick_idx;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (!req_i[owner_q]) begin
                        gap_q   <= GAP_LOAD;
                        state_q <= StGap;
                    end else begin
                        data_q  <= req_data_i[8*owner_q +: 8];
                        last_q  <= req_last_i[owner_q];
                        xmit_q  <= 1'b1;
                        state_q <= StGo;
                    end
                end
                StGo: begin
                    if (!tx_empty_i) begin
                        xmit_q         <= 1'b0;
                        ack_q[owner_q] <= 1'b1;
                        state_q        <= StWait;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        xmit_q  <= 1'b0;
                        tmo_q   <= 1'b1;
                        gap_q   <= GAP_LOAD;
                        state_q <= StGap;
                    end else begin
                        wd_q <= wd_q + TW'(1);
                    end
`endif
                end
                StWait: begin
                    if (tx_empty_i) begin
                        if (last_q) begin
                            gap_q   <= GAP_LOAD;
                            state_q <= StGap;
                        end else begin
                            state_q <= StLoad;
                        end
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        tmo_q   <= 1'b1;
                        gap_q   <= GAP_LOAD;
                        state_q <= StGap;
                    end else begin
                        wd_q <= wd_q + TW'(1);
                    end
`endif
                end
                StGap: begin
                    if (gap_q == '0) begin
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack_o     = ack_q;
    assign xmit_go_o = xmit_q;
    assign tx_data_o = data_q;
    assign owner_o   = owner_q;
    assign busy_o    = busy_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
    assign timeout_err_o = tmo_q;
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule
